// File: rtl/adx_mem_resp.sv
// adx_mem_resp -- memory-side responder for the m6502 address path.
//
// Accepts a CPU access (ADL/ADH address bytes, R/W, write data), waits
// WAIT_STATES cycles, runs one cycle on a 1-cycle synchronous RAM and
// returns read data with a one-cycle rdy pulse. A new request may be
// accepted in the RESP cycle, giving one access per WAIT_STATES+2 cycles.
//
// Optional feature macro: ZP_FAST_EN -- zero-page accesses (adh==8'h00)
// skip the wait states entirely (latency 2).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req, adl, adh, rw, di  CPU request, address bytes, 1=read, write data
//   dout, rdy, busy     read data (bypassed while rdy), done pulse, in-progress
//   mem_addr, mem_en, mem_we, mem_wdata, mem_rdata  sync-RAM interface
//
// WAIT_STATES must lie in 0..15 (4-bit wait counter).
module adx_mem_resp #(
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [7:0]  adl,
  input  logic [7:0]  adh,
  input  logic        rw,
  input  logic [7:0]  di,
  output logic [7:0]  dout,
  output logic        rdy,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       rw_q;
  logic [7:0] dout_q;
  logic       accept;
  logic       fast;

  // Requests are only looked at when the responder is free: IDLE, or the
  // RESP cycle of the previous access (back-to-back).
  assign accept = req && ((state == S_IDLE) || (state == S_RESP));

`ifdef ZP_FAST_EN
  assign fast = (adh == 8'h00);
`else
  assign fast = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rw_q      <= 1'b1;
      dout_q    <= 8'h00;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        S_ACCESS: state <= S_RESP;
        S_RESP: begin
          if (rw_q) dout_q <= mem_rdata;
          state <= S_IDLE;
        end
        default: ;
      endcase
      // Acceptance overrides the RESP->IDLE move above.
      if (accept) begin
        mem_addr  <= {adh, adl};
        rw_q      <= rw;
        mem_wdata <= di;
        cnt       <= CNT_INIT;
        state     <= (!HAS_WAIT || fast) ? S_ACCESS : S_WAIT;
      end
    end
  end

  // Reset gates the strobes in the same cycle so an abandoned access never
  // touches the RAM or signals completion.
  assign mem_en = (state == S_ACCESS) && !reset;
  assign mem_we = mem_en && !rw_q;
  assign rdy    = (state == S_RESP) && !reset;
  assign busy   = (state != S_IDLE);
  // RAM data lands in the RESP cycle; bypass it so the CPU sees it with rdy.
  assign dout   = (rdy && rw_q) ? mem_rdata : dout_q;

endmodule

// File: tb/tb_adx_mem_resp.sv
// Self-checking bench for adx_mem_resp: a transaction-level model checks the
// WAIT_STATES=2 instance every cycle; a second instance covers WAIT_STATES=0
// (or 3 with ZP_FAST_EN defined) with hand-computed latencies.
module tb_adx_mem_resp;
  localparam int WS0 = 2;
`ifdef ZP_FAST_EN
  localparam int WS1 = 3;
`else
  localparam int WS1 = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req, rw, req1, rw1;
  logic [7:0] adl, adh, di, adl1, adh1, di1;
  logic [7:0] dout, dout1, mem_wdata, mem_wdata1, mem_rdata, mem_rdata1;
  logic rdy, busy, mem_en, mem_we, rdy1, busy1, mem_en1, mem_we1;
  logic [15:0] mem_addr, mem_addr1;

  adx_mem_resp #(.WAIT_STATES(WS0)) u0 (
    .clk(clk), .reset(rst), .req(req), .adl(adl), .adh(adh), .rw(rw), .di(di),
    .dout(dout), .rdy(rdy), .busy(busy), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  adx_mem_resp #(.WAIT_STATES(WS1)) u1 (
    .clk(clk), .reset(rst), .req(req1), .adl(adl1), .adh(adh1), .rw(rw1), .di(di1),
    .dout(dout1), .rdy(rdy1), .busy(busy1), .mem_addr(mem_addr1), .mem_en(mem_en1),
    .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

  // RAMs and the model's reference memory
  logic [7:0] ram0 [0:65535];
  logic [7:0] ram1 [0:65535];
  logic [7:0] mdl_mem [0:65535];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram0[mem_addr];
      if (mem_we) ram0[mem_addr] = mem_wdata;
    end
  end
  always @(posedge clk) begin
    if (mem_en1) begin
      mem_rdata1 <= ram1[mem_addr1];
      if (mem_we1) ram1[mem_addr1] = mem_wdata1;
    end
  end

  int total = 0, passes = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction model: an accepted access completes lat cycles later.
  bit pending = 0, rw_m = 1, in_resp;
  int cyc = 0, due = 0;
  logic [15:0] addr_m = 0;
  logic [7:0] wdata_m = 0, dout_m = 0;

  function automatic int lat0(input logic [7:0] h);
`ifdef ZP_FAST_EN
    if (h == 8'h00) return 2;
`endif
    return WS0 + 2;
  endfunction

  task automatic check();
    bit rdy_e, en_e;
    rdy_e = pending && (cyc == due);
    en_e  = pending && (cyc == due - 1);
    if (rst) begin
      chk("rdy_in_reset", rdy, 0);
      chk("mem_en_in_reset", mem_en, 0);
      chk("mem_we_in_reset", mem_we, 0);
    end else begin
      chk("rdy", rdy, rdy_e);
      chk("busy", busy, pending);
      chk("mem_en", mem_en, en_e);
      chk("mem_we", mem_we, en_e && !rw_m);
      chk("mem_addr", mem_addr, addr_m);
      chk("mem_wdata", mem_wdata, wdata_m);
      chk("dout", dout, (rdy_e && rw_m) ? mdl_mem[addr_m] : dout_m);
    end
  endtask

  task automatic step();
    @(posedge clk);
    in_resp = pending && (cyc == due);
    cyc++;
    if (rst) begin
      pending = 0; dout_m = 0; addr_m = 0; wdata_m = 0; rw_m = 1;
    end else begin
      if (in_resp) begin
        pending = 0;
        if (rw_m) dout_m = mdl_mem[addr_m];
        else      mdl_mem[addr_m] = wdata_m;
      end
      if (req && !pending) begin
        pending = 1; addr_m = {adh, adl}; rw_m = rw; wdata_m = di;
        due = cyc + lat0(adh) - 1;
      end
    end
    @(negedge clk);
    check();
  endtask

  // Wait for rdy on instance 0 (sel=0) or 1; j = cycles waited after accept.
  task automatic wait_rdy(input bit sel, output int j);
    j = 0;
    while (((sel ? rdy1 : rdy) !== 1'b1) && j < 20) begin step(); j++; end
    if (j >= 20) chk("rdy_timeout", 0, 1);
  endtask

  task automatic acc(input logic [7:0] h, input logic [7:0] l, input logic r,
                     input logic [7:0] d, output int lat, output logic [7:0] q);
    int j;
    adh = h; adl = l; rw = r; di = d; req = 1;
    step();
    req = 0;
    wait_rdy(0, j);
    lat = j + 1; q = dout;
    step();
  endtask

  task automatic acc1(input logic [7:0] h, input logic [7:0] l,
                      output int lat, output logic [7:0] q);
    int j;
    adh1 = h; adl1 = l; rw1 = 1; di1 = 0; req1 = 1;
    step();
    req1 = 0;
    wait_rdy(1, j);
    lat = j + 1; q = dout1;
    step();
  endtask

  initial begin
    int lat, j;
    logic [7:0] q;
    for (int i = 0; i < 65536; i++) begin
      ram0[i] = 8'(i ^ (i >> 8)); ram1[i] = ram0[i]; mdl_mem[i] = ram0[i];
    end
    ram0[16'h1234] = 8'hA5; mdl_mem[16'h1234] = 8'hA5;
    rst = 1; req = 0; rw = 1; adl = 0; adh = 0; di = 0;
    req1 = 0; rw1 = 1; adl1 = 0; adh1 = 0; di1 = 0;
    step(); step();
    chk("reset_busy", busy, 0);
    chk("reset_dout", dout, 8'h00);
    chk("reset_mem_addr", mem_addr, 16'h0000);
    rst = 0;
    step();

    // 1: read 1234
    acc(8'h12, 8'h34, 1, 8'h00, lat, q);
    chk("t1_latency", lat, 4);
    chk("t1_dout", q, 8'hA5);
    // 2: write 0200 then read it back
    acc(8'h02, 8'h00, 0, 8'h3C, lat, q);
    chk("t2_latency", lat, 4);
    chk("t2_dout_held", q, 8'hA5);
    acc(8'h02, 8'h00, 1, 8'h00, lat, q);
    chk("t2_readback", q, 8'h3C);

    // 3: back-to-back reads 0010, 0011
    adh = 8'h00; adl = 8'h10; rw = 1; req = 1;
    step();
    adl = 8'h11;
    wait_rdy(0, j);
    chk("t3_first_dout", dout, 8'h10);
    step();
    chk("t3_busy_between", busy, 1);
    req = 0;
    wait_rdy(0, j);
`ifdef ZP_FAST_EN
    chk("t3_interval", j + 1, 2);
`else
    chk("t3_interval", j + 1, 4);
`endif
    chk("t3_second_dout", dout, 8'h11);
    step();

    // 4: reset during WAIT of a write to 0300
    adh = 8'h03; adl = 8'h00; rw = 0; di = 8'h77; req = 1;
    step();
    req = 0; rst = 1;
    step();
    rst = 0;
    chk("t4_rdy", rdy, 0);
    chk("t4_mem_en", mem_en, 0);
    chk("t4_busy", busy, 0);
    chk("t4_dout", dout, 8'h00);
    step(); step(); step();
    acc(8'h03, 8'h00, 1, 8'h00, lat, q);
    chk("t4_no_write", q, 8'h03);

    // 5/6: second instance
`ifdef ZP_FAST_EN
    acc1(8'h00, 8'h42, lat, q);
    chk("t6_zp_latency", lat, 2);
    chk("t6_zp_dout", q, 8'h42);
    acc1(8'h01, 8'h42, lat, q);
    chk("t6_p1_latency", lat, 5);
    chk("t6_p1_dout", q, 8'h43);
`else
    acc1(8'h80, 8'h00, lat, q);
    chk("t5_latency", lat, 2);
    chk("t5_dout", q, 8'h80);
`endif
    chk("u1_idle_after", busy1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
